// File: rtl/fifo_word_serializer.sv
// Word-to-byte serializer feeding an 8-bit FIFO write port, LSB first.
// Define SER_CHECKSUM_EN to append an XOR checksum byte per packet.
module fifo_word_serializer #(
    parameter int NUM_BYTES = 4,
    parameter int BYTE_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0] in_data,
    input  logic                        in_last,
    input  logic [2:0]                  in_nbytes,
    output logic                        wr_en,
    output logic [BYTE_W-1:0]           data_in,
    input  logic                        full,
    output logic                        busy,
    output logic [15:0]                 pkt_count
);

    localparam int IDX_W = $clog2(NUM_BYTES);

`ifdef SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t                             state_q, state_d;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   word_q, word_d;
    logic                               last_q, last_d;
    logic [2:0]                         nb_q, nb_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [15:0]                        pkt_q, pkt_d;
`ifdef SER_CHECKSUM_EN
    logic [BYTE_W-1:0]                  csum_q, csum_d;
`endif

    logic [BYTE_W-1:0] cur_byte;
    logic              eow;
    logic [2:0]        in_nb;
    logic              load;

    assign cur_byte = word_q[idx_q];
    assign eow      = (3'(idx_q) == nb_q - 3'd1);

    // Out-of-range byte counts on a last word mean a full word.
    always_comb begin
        in_nb = 3'd4;
        if (in_last && in_nbytes != 3'd0 && in_nbytes <= 3'd4) begin
            in_nb = in_nbytes;
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        last_d   = last_q;
        nb_d     = nb_q;
        idx_d    = idx_q;
        pkt_d    = pkt_q;
`ifdef SER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        wr_en    = 1'b0;
        data_in  = '0;
        in_ready = 1'b0;
        load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            SEND: begin
                data_in = cur_byte;
                wr_en   = !full;
                if (wr_en) begin
                    idx_d = idx_q + IDX_W'(1);
`ifdef SER_CHECKSUM_EN
                    csum_d = csum_q ^ cur_byte;
`endif
                    if (eow) begin
                        state_d = IDLE;
                        if (!last_q) begin
                            in_ready = 1'b1;
                        end else begin
`ifdef SER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            pkt_d    = pkt_q + 16'd1;
                            in_ready = 1'b1;
`endif
                        end
                        // Zero-bubble handoff to the next word.
                        load = in_valid && in_ready;
                    end
                end
            end
`ifdef SER_CHECKSUM_EN
            CSUM: begin
                data_in = csum_q;
                wr_en   = !full;
                if (wr_en) begin
                    pkt_d   = pkt_q + 16'd1;
                    csum_d  = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (load) begin
            word_d  = in_data;
            last_d  = in_last;
            nb_d    = in_nb;
            idx_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            nb_q    <= 3'd4;
            idx_q   <= '0;
            pkt_q   <= '0;
`ifdef SER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            nb_q    <= nb_d;
            idx_q   <= idx_d;
            pkt_q   <= pkt_d;
`ifdef SER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer (checksum macro undefined).
// Cycle table plus hand sequences for FIFO fill and async reset.
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_nbytes = '0;
    logic        wr_en;
    logic [7:0]  data_in;
    logic        full = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    fifo_word_serializer #(.NUM_BYTES(4), .BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .full      (full),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic [2:0]  nb;
        logic        f;
        logic        wr;
        logic [7:0]  dat;
        logic        rdy;
        logic        bsy;
        logic [15:0] pkt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, input logic [31:0] d, input logic l,
        input logic [2:0] nb, input logic f, input logic wr,
        input logic [7:0] dat, input logic rdy, input logic bsy,
        input logic [15:0] pkt);
        vec_t r;
        r.v = v;   r.d = d;     r.l = l;     r.nb = nb;   r.f = f;
        r.wr = wr; r.dat = dat; r.rdy = rdy; r.bsy = bsy; r.pkt = pkt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fword(input int k);
        return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    endfunction

    initial begin
        int cnt;
        int k;
        int bad;
        logic acc;
        logic [7:0] exp_b;
        logic [31:0] w;

        // single last word
        vecs.push_back(mk(1, 32'h44332211, 1, 4, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h11, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h22, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h33, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h44, 1, 1, 0));
        // two-word packet, back to back
        vecs.push_back(mk(1, 32'h04030201, 0, 0, 0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mk(1, 32'h00000605, 1, 2, 0, 1, 8'h01, 0, 1, 1));
        vecs.push_back(mk(1, 32'h00000605, 1, 2, 0, 1, 8'h02, 0, 1, 1));
        vecs.push_back(mk(1, 32'h00000605, 1, 2, 0, 1, 8'h03, 0, 1, 1));
        vecs.push_back(mk(1, 32'h00000605, 1, 2, 0, 1, 8'h04, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h05, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h06, 1, 1, 1));
        // full stall on second and last bytes
        vecs.push_back(mk(1, 32'hDDCCBBAA, 1, 4, 0, 0, 8'h00, 1, 0, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'hAA, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 8'hBB, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 8'hBB, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 8'hBB, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'hBB, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'hCC, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 8'hDD, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'hDD, 1, 1, 2));
        // nbytes 0 means 4; then 1-byte word, then nbytes 7 means 4
        vecs.push_back(mk(1, 32'h87654321, 1, 0, 0, 0, 8'h00, 1, 0, 3));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h21, 0, 1, 3));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h43, 0, 1, 3));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h65, 0, 1, 3));
        vecs.push_back(mk(1, 32'h000000AB, 1, 1, 0, 1, 8'h87, 1, 1, 3));
        vecs.push_back(mk(1, 32'h000000CD, 1, 7, 0, 1, 8'hAB, 1, 1, 4));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'hCD, 0, 1, 5));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h00, 0, 1, 5));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h00, 0, 1, 5));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 8'h00, 1, 1, 5));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 8'h00, 1, 0, 6));

        #3;
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pkt", 32'(pkt_count), 32'h0);
        chk("rst_data", 32'(data_in), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            in_last   = vecs[i].l;
            in_nbytes = vecs[i].nb;
            full      = vecs[i].f;
            #1;
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
            chk($sformatf("v%0d_data", i), 32'(data_in), 32'(vecs[i].dat));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d_pkt", i), 32'(pkt_count), 32'(vecs[i].pkt));
            @(negedge clk);
        end

        // 16-deep FIFO with no reads, five non-last words
        cnt = 0;
        k = 0;
        bad = 0;
        in_last = 1'b0;
        in_nbytes = 3'd0;
        for (int c = 0; c < 30; c++) begin
            full = (cnt >= 16);
            in_valid = (k < 5);
            w = fword(k);
            in_data = w;
            #1;
            if (wr_en) begin
                exp_b = 8'(cnt + 1);
                if (data_in !== exp_b) bad++;
                cnt++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
        end
        full = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("fifo_writes", 32'(cnt), 32'd16);
        chk("fifo_order_errs", 32'(bad), 32'd0);
        chk("fifo_words_accepted", 32'(k), 32'd5);
        chk("stall_wr_en", 32'(wr_en), 32'h0);
        chk("stall_busy", 32'(busy), 32'h1);
        chk("stall_data", 32'(data_in), 32'h11);
        chk("stall_in_ready", 32'(in_ready), 32'h0);

        // release full, send two bytes, then reset between edges
        @(negedge clk);
        full = 1'b0;
        #1;
        chk("resume_b0", 32'(data_in), 32'h11);
        chk("resume_b0_wr", 32'(wr_en), 32'h1);
        @(negedge clk);
        #1;
        chk("resume_b1", 32'(data_in), 32'h12);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_pkt", 32'(pkt_count), 32'h0);
        chk("arst_data", 32'(data_in), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_ready", 32'(in_ready), 32'h1);
        chk("arst_hold_wr_en", 32'(wr_en), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h55667788;
        in_last = 1'b1;
        in_nbytes = 3'd4;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post_rst_b0_wr", 32'(wr_en), 32'h1);
        chk("post_rst_b0", 32'(data_in), 32'h88);
        @(negedge clk);
        #1;
        chk("post_rst_b1", 32'(data_in), 32'h77);
        @(negedge clk);
        #1;
        chk("post_rst_b2", 32'(data_in), 32'h66);
        @(negedge clk);
        #1;
        chk("post_rst_b3", 32'(data_in), 32'h55);
        @(negedge clk);
        #1;
        chk("post_rst_pkt", 32'(pkt_count), 32'h1);
        chk("post_rst_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
